// File: rtl/ysyx_22041071_wb_stage_if.sv
// Write-back stage bundle: MEM-side entry, register-file write port,
// commit/difftest handshake and hazard mask.
interface ysyx_22041071_wb_stage_if;
  // MEM -> WB entry
  logic        valid5;
  logic        ready5;
  logic [63:0] PC5;
  logic [31:0] Ins4;
  logic        WB_sel3;
  logic        reg_w_en3;
  logic [4:0]  rdest3;
  logic [63:0] result3;
  logic [63:0] R_data;
  logic [2:0]  addr_lo;
  // register-file write port
  logic        reg_w_en5;
  logic [4:0]  rdest4;
  logic [63:0] WB_data2;
  // commit / difftest
  logic        commit_valid;
  logic        commit_ready;
  logic [63:0] commit_PC;
  logic [31:0] commit_Ins;
  // hazard
  logic [31:0] pend_mask;

  // Producer side: MEM stage plus the commit consumer
  modport master (
    output valid5, PC5, Ins4, WB_sel3, reg_w_en3, rdest3, result3, R_data, addr_lo,
    output commit_ready,
    input  ready5, reg_w_en5, rdest4, WB_data2,
    input  commit_valid, commit_PC, commit_Ins, pend_mask
  );

  // The WB stage itself
  modport slave (
    input  valid5, PC5, Ins4, WB_sel3, reg_w_en3, rdest3, result3, R_data, addr_lo,
    input  commit_ready,
    output ready5, reg_w_en5, rdest4, WB_data2,
    output commit_valid, commit_PC, commit_Ins, pend_mask
  );
endinterface

// File: rtl/ysyx_22041071_wb_stage.sv
// Write-back stage: 2-entry in-order buffer between MEM and the register
// file. Load data is extracted at enqueue so each entry holds final write
// data; the head entry drives the regfile write and commit port.
module ysyx_22041071_wb_stage (
  input  logic                           clk,
  input  logic                           reset,
  ysyx_22041071_wb_stage_if.slave        bus
);

  // Select and extend the loaded lane according to funct3.
  function automatic logic [63:0] load_extract(
    input logic [2:0]  funct3,
    input logic [63:0] rdata,
    input logic [2:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[2:1], 4'b0000} +: 16];
    w = rdata[{off[2], 5'b00000} +: 32];
    case (funct3)
      3'b000:  load_extract = {{56{b[7]}}, b};
      3'b100:  load_extract = {56'd0, b};
      3'b001:  load_extract = {{48{h[15]}}, h};
      3'b101:  load_extract = {48'd0, h};
      3'b010:  load_extract = {{32{w[31]}}, w};
      3'b110:  load_extract = {32'd0, w};
      3'b011:  load_extract = rdata;
      default: load_extract = rdata;
    endcase
  endfunction

  logic [1:0]  count_q, count_d;
  logic        wptr_q, rptr_q;
  logic        init_q;
  logic [63:0] pc_q   [2];
  logic [31:0] ins_q  [2];
  logic        wen_q  [2];
  logic [4:0]  rd_q   [2];
  logic [63:0] data_q [2];

  logic        ready_s;
  logic        cvalid_s;
  logic        enq_s;
  logic        fire_s;
  logic [63:0] wdata_s;
  logic [1:0]  ent_valid_s;
  logic [31:0] pend_s;

  // init_q keeps ready5 low through reset and lets it rise on the first edge after.
  assign ready_s  = init_q & (count_q != 2'd2);
  assign cvalid_s = (count_q != 2'd0);
  assign enq_s    = bus.valid5 & ready_s;
  assign fire_s   = cvalid_s & bus.commit_ready;
  assign wdata_s  = bus.WB_sel3 ? load_extract(bus.Ins4[14:12], bus.R_data, bus.addr_lo)
                                : bus.result3;

  // Occupancy next state from the enqueue/commit pair.
  always_comb begin
    count_d = count_q;
    case ({enq_s, fire_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Buffer storage, pointers and occupancy; reset wipes everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      init_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= 64'd0;
        ins_q[i]  <= 32'd0;
        wen_q[i]  <= 1'b0;
        rd_q[i]   <= 5'd0;
        data_q[i] <= 64'd0;
      end
    end else begin
      init_q  <= 1'b1;
      count_q <= count_d;
      if (enq_s) begin
        pc_q[wptr_q]   <= bus.PC5;
        ins_q[wptr_q]  <= bus.Ins4;
        wen_q[wptr_q]  <= bus.reg_w_en3;
        rd_q[wptr_q]   <= bus.rdest3;
        data_q[wptr_q] <= wdata_s;
        wptr_q         <= ~wptr_q;
      end
      if (fire_s) begin
        rptr_q <= ~rptr_q;
      end
    end
  end

  // Which physical slots currently hold live entries.
  always_comb begin
    ent_valid_s = 2'b00;
    if (count_q == 2'd2) begin
      ent_valid_s = 2'b11;
    end else if (count_q == 2'd1) begin
      ent_valid_s[rptr_q] = 1'b1;
    end else begin
      ent_valid_s = 2'b00;
    end
  end

  // Pending-write mask over live entries; x0 never counts as a hazard.
  always_comb begin
    pend_s = 32'd0;
    for (int i = 0; i < 2; i++) begin
      pend_s = pend_s |
               ({31'd0, ent_valid_s[i] & wen_q[i] & (rd_q[i] != 5'd0)} << rd_q[i]);
    end
    pend_s[0] = 1'b0;
  end

  assign bus.ready5       = ready_s;
  assign bus.commit_valid = cvalid_s;
  assign bus.commit_PC    = pc_q[rptr_q];
  assign bus.commit_Ins   = ins_q[rptr_q];
  assign bus.rdest4       = rd_q[rptr_q];
  assign bus.WB_data2     = data_q[rptr_q];
  assign bus.reg_w_en5    = fire_s & wen_q[rptr_q] & (rd_q[rptr_q] != 5'd0);
  assign bus.pend_mask    = pend_s;

endmodule

// File: tb/tb_ysyx_22041071_wb_stage.sv
// Bench for the write-back stage: directed scenarios followed by random
// traffic, compared against a queue-based reference model.
module tb_ysyx_22041071_wb_stage;

  logic clk;
  logic reset;

  ysyx_22041071_wb_stage_if wb_if ();

  ysyx_22041071_wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  entry_t q[$];
  bit     init;
  int     checks;
  int     errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load: size/lane derived arithmetically from funct3 and offset.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] rdata,
                                           input int off);
    int          sz;
    int          lane;
    logic [63:0] mask;
    logic [63:0] v;
    if (f3 == 3'd7) return rdata;
    sz   = 1 << f3[1:0];
    lane = off - (off % sz);
    mask = (sz == 8) ? ~64'd0 : ((64'd1 << (8 * sz)) - 64'd1);
    v    = (rdata >> (8 * lane)) & mask;
    if (!f3[2] && sz < 8 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] mk_ins(input logic [2:0] f3);
    return {17'd0, f3, 5'd1, 7'h03};
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic sel, input logic wen, input logic [4:0] rd,
                       input logic [63:0] res, input logic [63:0] rdata,
                       input logic [2:0] off, input logic crdy);
    wb_if.valid5       = v;
    wb_if.PC5          = pc;
    wb_if.Ins4         = ins;
    wb_if.WB_sel3      = sel;
    wb_if.reg_w_en3    = wen;
    wb_if.rdest3       = rd;
    wb_if.result3      = res;
    wb_if.R_data       = rdata;
    wb_if.addr_lo      = off;
    wb_if.commit_ready = crdy;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model.
  task automatic cycle();
    bit          cv;
    bit          fire;
    bit          enq;
    logic [31:0] pend;
    entry_t      e;
    @(negedge clk);
    cv   = (q.size() != 0);
    fire = cv && wb_if.commit_ready;
    enq  = wb_if.valid5 && init && (q.size() < 2);
    pend = 32'd0;
    foreach (q[k]) if (q[k].wen && q[k].rd != 5'd0) pend[q[k].rd] = 1'b1;
    chk("ready5", wb_if.ready5, init && (q.size() < 2));
    chk("commit_valid", wb_if.commit_valid, cv);
    chk("pend_mask", wb_if.pend_mask, pend);
    chk("reg_w_en5", wb_if.reg_w_en5, fire && q[0].wen && (q[0].rd != 5'd0));
    if (cv) begin
      chk("commit_PC", wb_if.commit_PC, q[0].pc);
      chk("commit_Ins", wb_if.commit_Ins, q[0].ins);
      chk("rdest4", wb_if.rdest4, q[0].rd);
      chk("WB_data2", wb_if.WB_data2, q[0].data);
    end
    e.pc   = wb_if.PC5;
    e.ins  = wb_if.Ins4;
    e.wen  = wb_if.reg_w_en3;
    e.rd   = wb_if.rdest3;
    e.data = wb_if.WB_sel3 ? ref_load(wb_if.Ins4[14:12], wb_if.R_data, int'(wb_if.addr_lo))
                           : wb_if.result3;
    @(posedge clk);
    if (fire) void'(q.pop_front());
    if (enq) q.push_back(e);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    init = 1'b0;
    chk("rst_ready5", wb_if.ready5, 1'b0);
    chk("rst_commit_valid", wb_if.commit_valid, 1'b0);
    chk("rst_reg_w_en5", wb_if.reg_w_en5, 1'b0);
    chk("rst_pend_mask", wb_if.pend_mask, 32'd0);
    chk("rst_rdest4", wb_if.rdest4, 5'd0);
    chk("rst_WB_data2", wb_if.WB_data2, 64'd0);
    chk("rst_commit_PC", wb_if.commit_PC, 64'd0);
    chk("rst_commit_Ins", wb_if.commit_Ins, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("ready5_before_edge", wb_if.ready5, 1'b0);
    @(posedge clk);
    #1;
    init = 1'b1;
    chk("ready5_after_edge", wb_if.ready5, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    init   = 1'b0;
    reset  = 1'b1;
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 3'd0, 1'b0);
    #2;
    chk("por_ready5", wb_if.ready5, 1'b0);
    chk("por_commit_valid", wb_if.commit_valid, 1'b0);
    chk("por_pend_mask", wb_if.pend_mask, 32'd0);
    #6;
    reset = 1'b0;
    @(posedge clk);
    #1;
    init = 1'b1;
    chk("por_ready5_rise", wb_if.ready5, 1'b1);

    // ALU result write to x5
    drive(1'b1, 64'h8000_0000, 32'h0000_0293, 1'b0, 1'b1, 5'd5, 64'h1234, 64'd0, 3'd0, 1'b1);
    cycle();
    wb_if.valid5 = 1'b0;
    chk("alu_wen", wb_if.reg_w_en5, 1'b1);
    chk("alu_rdest", wb_if.rdest4, 5'd5);
    chk("alu_data", wb_if.WB_data2, 64'h1234);
    chk("alu_pend", wb_if.pend_mask, 32'h0000_0020);
    cycle();
    chk("alu_pend_clear", wb_if.pend_mask, 32'd0);

    // LB / LBU at byte lane 1
    drive(1'b1, 64'h8000_0004, mk_ins(3'b000), 1'b1, 1'b1, 5'd6, 64'd0,
          64'h0000_0000_0000_80FF, 3'd1, 1'b1);
    cycle();
    wb_if.valid5 = 1'b0;
    chk("lb_data", wb_if.WB_data2, 64'hFFFF_FFFF_FFFF_FF80);
    cycle();
    drive(1'b1, 64'h8000_0008, mk_ins(3'b100), 1'b1, 1'b1, 5'd6, 64'd0,
          64'h0000_0000_0000_80FF, 3'd1, 1'b1);
    cycle();
    wb_if.valid5 = 1'b0;
    chk("lbu_data", wb_if.WB_data2, 64'h0000_0000_0000_0080);
    cycle();

    // LW / LWU at word lane 1
    drive(1'b1, 64'h8000_000C, mk_ins(3'b010), 1'b1, 1'b1, 5'd7, 64'd0,
          64'h8000_0000_0000_0001, 3'd4, 1'b1);
    cycle();
    wb_if.valid5 = 1'b0;
    chk("lw_data", wb_if.WB_data2, 64'hFFFF_FFFF_8000_0000);
    cycle();
    drive(1'b1, 64'h8000_0010, mk_ins(3'b110), 1'b1, 1'b1, 5'd7, 64'd0,
          64'h8000_0000_0000_0001, 3'd4, 1'b1);
    cycle();
    wb_if.valid5 = 1'b0;
    chk("lwu_data", wb_if.WB_data2, 64'h0000_0000_8000_0000);
    cycle();

    // Backpressure: two accepted, third refused, then in-order drain
    drive(1'b1, 64'hA000, 32'h0000_0113, 1'b0, 1'b1, 5'd2, 64'h11, 64'd0, 3'd0, 1'b0);
    cycle();
    wb_if.PC5 = 64'hA004; wb_if.rdest3 = 5'd3; wb_if.result3 = 64'h22;
    cycle();
    chk("bp_full_ready", wb_if.ready5, 1'b0);
    wb_if.PC5 = 64'hA008; wb_if.rdest3 = 5'd4; wb_if.result3 = 64'h33;
    cycle();
    cycle();
    chk("bp_hold_pc", wb_if.commit_PC, 64'hA000);
    chk("bp_pend", wb_if.pend_mask, 32'h0000_000C);
    wb_if.valid5       = 1'b0;
    wb_if.commit_ready = 1'b1;
    cycle();
    chk("bp_second_pc", wb_if.commit_PC, 64'hA004);
    cycle();
    chk("bp_drained", wb_if.commit_valid, 1'b0);

    // x0 destination commits without a register write
    drive(1'b1, 64'hB000, 32'h0000_0013, 1'b0, 1'b1, 5'd0, 64'h55, 64'd0, 3'd0, 1'b1);
    cycle();
    wb_if.valid5 = 1'b0;
    chk("x0_cvalid", wb_if.commit_valid, 1'b1);
    chk("x0_pc", wb_if.commit_PC, 64'hB000);
    chk("x0_wen", wb_if.reg_w_en5, 1'b0);
    chk("x0_pend", wb_if.pend_mask, 32'd0);
    cycle();

    // Reset with two entries buffered
    drive(1'b1, 64'hC000, 32'h0000_0193, 1'b0, 1'b1, 5'd3, 64'h66, 64'd0, 3'd0, 1'b0);
    cycle();
    wb_if.PC5 = 64'hC004; wb_if.rdest3 = 5'd7;
    cycle();
    chk("rst_pre_pend", wb_if.pend_mask, 32'h0000_0088);
    wb_if.valid5       = 1'b0;
    wb_if.commit_ready = 1'b1;
    do_reset();
    cycle();
    cycle();

    // Random traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, {$urandom, $urandom}, mk_ins(3'($urandom)) ^ {$urandom} & 32'hFFFF_8F80,
            1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, 3'($urandom), ($urandom % 3) != 0);
      if (i == 200) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
